// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage for the DLX control unit.
// Holds the PC, runs a req/rvalid handshake with instruction memory,
// keeps the fetched word in the IR until the control unit takes it,
// and accepts PC redirects from taken branches and jumps.
module instr_fetch_unit #(
  parameter int                   ADDR_SIZE    = 32,
  parameter int                   INSTR_SIZE   = 32,
  parameter int                   OP_CODE_SIZE = 6,
  parameter int                   FUNC_SIZE    = 11,
  parameter logic [ADDR_SIZE-1:0] RESET_PC     = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_en,
  output logic                    imem_req,
  output logic [ADDR_SIZE-1:0]    imem_addr,
  input  logic                    imem_rvalid,
  input  logic [INSTR_SIZE-1:0]   imem_rdata,
  output logic                    ir_valid,
  input  logic                    cu_ready,
  output logic [OP_CODE_SIZE-1:0] opcode,
  output logic [FUNC_SIZE-1:0]    func,
  output logic [INSTR_SIZE-1:0]   ir,
  output logic [ADDR_SIZE-1:0]    npc,
  input  logic                    redirect,
  input  logic [ADDR_SIZE-1:0]    redirect_pc
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  localparam logic [ADDR_SIZE-1:0] PC_STEP   = ADDR_SIZE'(4);
  localparam logic [ADDR_SIZE-1:0] RESET_NPC = RESET_PC + PC_STEP;
  localparam logic [ADDR_SIZE-1:0] WORD_MASK = ~ADDR_SIZE'(3);

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_SIZE-1:0]    pc;
  logic [ADDR_SIZE-1:0]    pc_plus4;
  logic [ADDR_SIZE-1:0]    npc_q;
  logic [INSTR_SIZE-1:0]   ir_q;
  logic                    accept_word;

  // PC arithmetic wraps naturally at the address width.
  assign pc_plus4    = pc + PC_STEP;
  // A returned word is only taken in FETCH and only when no redirect discards it.
  assign accept_word = (state == FETCH) && imem_rvalid && !redirect;

  // State register; reset wins over everything, including a fetch in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a redirect restarts fetching (or idles) and drops any held IR.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (fetch_en) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        if (redirect) begin
          next_state = FETCH;
        end else if (imem_rvalid) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (redirect || cu_ready) begin
          next_state = fetch_en ? FETCH : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode: request only while fetching, IR valid only while holding.
  always_comb begin
    imem_req = 1'b0;
    ir_valid = 1'b0;
    case (state)
      FETCH:   imem_req = 1'b1;
      HOLD:    ir_valid = 1'b1;
      default: begin
        imem_req = 1'b0;
        ir_valid = 1'b0;
      end
    endcase
  end

  // PC / IR / NPC registers; redirect target is forced word-aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      ir_q  <= '0;
      npc_q <= RESET_NPC;
    end else if (redirect) begin
      pc <= redirect_pc & WORD_MASK;
    end else if (accept_word) begin
      ir_q  <= imem_rdata;
      pc    <= pc_plus4;
      npc_q <= pc_plus4;
    end
  end

  assign imem_addr = pc;
  assign ir        = ir_q;
  assign npc       = npc_q;
  assign opcode    = ir_q[INSTR_SIZE-1 -: OP_CODE_SIZE];
  assign func      = ir_q[FUNC_SIZE-1:0];

endmodule
